// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and constants for the instruction/data memory bus arbiter
package mem_bus_arbiter_pkg;

    localparam int DATA_W = 32;

    // Access size encodings carried on data_size / bus_size
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4
    } arb_state_e;

    // True for the two states that carry a fetch on the bus
    function automatic logic is_inst_state(input arb_state_e st);
        return (st == I_ADDR) || (st == I_DATA);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - single-outstanding arbiter of fetch and load/store onto one SRAM-like bus (round-robin option: MEM_ARB_RR_EN)
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic [DATA_W-1:0] inst_addr,
    input  logic              inst_cancel,
    output logic [DATA_W-1:0] inst_rdata,
    output logic              inst_data_ok,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [DATA_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_data_ok,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [DATA_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic              if_stall,
    output logic              mem_stall
);

    arb_state_e        state_q, state_d;
    logic [DATA_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q,  size_d;
    logic              wr_q,    wr_d;
    logic              drop_q,  drop_d;

    logic              grant_data;
    logic              inst_done;
    logic              data_done;
    logic              req_out;
    logic              drop_now;

`ifdef MEM_ARB_RR_EN
    // last_q = 1 means the most recent grant went to the data side
    logic              last_q, last_d;

    // Round-robin: on a tie, the side that did not win last time goes first
    always_comb begin
        grant_data = data_req & ~(inst_req & last_q);
    end
`else
    // Fixed priority: loads/stores always win over fetches
    always_comb begin
        grant_data = data_req;
    end
`endif

    // A cancel arriving in the completing cycle must still suppress the fetch
    assign drop_now = drop_q | inst_cancel;

    // Next-state, request latching and completion strobes
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        wr_d      = wr_q;
        drop_d    = drop_q;
        inst_done = 1'b0;
        data_done = 1'b0;
        req_out   = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d    = last_q;
`endif

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                if (grant_data) begin
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    size_d  = data_size;
                    wr_d    = data_wr;
                    state_d = D_ADDR;
`ifdef MEM_ARB_RR_EN
                    last_d  = 1'b1;
`endif
                end else if (inst_req) begin
                    addr_d  = inst_addr;
                    wdata_d = '0;
                    size_d  = SZ_WORD;
                    wr_d    = 1'b0;
                    state_d = I_ADDR;
`ifdef MEM_ARB_RR_EN
                    last_d  = 1'b0;
`endif
                end
            end

            I_ADDR: begin
                req_out = 1'b1;
                if (inst_cancel) begin
                    drop_d = 1'b1;
                end
                // A slave may accept and complete in the same cycle
                if (bus_addr_ok && bus_data_ok) begin
                    inst_done = ~drop_now;
                    drop_d    = 1'b0;
                    state_d   = IDLE;
                end else if (bus_addr_ok) begin
                    state_d = I_DATA;
                end
            end

            I_DATA: begin
                if (inst_cancel) begin
                    drop_d = 1'b1;
                end
                if (bus_data_ok) begin
                    inst_done = ~drop_now;
                    drop_d    = 1'b0;
                    state_d   = IDLE;
                end
            end

            D_ADDR: begin
                req_out = 1'b1;
                if (bus_addr_ok && bus_data_ok) begin
                    data_done = 1'b1;
                    state_d   = IDLE;
                end else if (bus_addr_ok) begin
                    state_d = D_DATA;
                end
            end

            D_DATA: begin
                if (bus_data_ok) begin
                    data_done = 1'b1;
                    state_d   = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched transaction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= SZ_BYTE;
            wr_q    <= 1'b0;
            drop_q  <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
            drop_q  <= drop_d;
`ifdef MEM_ARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    // Bus side is driven only from the latched copy so it stays stable while waiting
    assign bus_req   = req_out;
    assign bus_wr    = wr_q;
    assign bus_size  = size_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

    // Completion strobes are masked during reset so an abandoned transaction never reports
    assign inst_data_ok = inst_done & ~rst;
    assign data_data_ok = data_done & ~rst;
    assign inst_rdata   = inst_data_ok ? bus_rdata : '0;
    assign data_rdata   = data_data_ok ? bus_rdata : '0;

    assign if_stall  = inst_req & ~inst_data_ok;
    assign mem_stall = data_req & ~data_data_ok;

    // The fetch-state helper is kept for debug visibility of the drop window
    logic in_fetch;
    assign in_fetch = is_inst_state(state_q);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_cancel, inst_data_ok;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_wr, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic        if_stall, mem_stall;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_cancel  (inst_cancel),
        .inst_rdata   (inst_rdata),
        .inst_data_ok (inst_data_ok),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_rdata   (data_rdata),
        .data_data_ok (data_data_ok),
        .bus_req      (bus_req),
        .bus_wr       (bus_wr),
        .bus_size     (bus_size),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_addr_ok  (bus_addr_ok),
        .bus_data_ok  (bus_data_ok),
        .bus_rdata    (bus_rdata),
        .if_stall     (if_stall),
        .mem_stall    (mem_stall)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1 ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling
    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        inst_req = 0; inst_addr = 0; inst_cancel = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = 0;
        cyc(); cyc();

        // Reset state
        settle();
        check_eq("rst_bus_req", bus_req, 0);
        check_eq("rst_inst_ok", inst_data_ok, 0);
        check_eq("rst_data_ok", data_data_ok, 0);
        check_eq("rst_inst_rdata", inst_rdata, 0);
        check_eq("rst_data_rdata", data_rdata, 0);
        check_eq("rst_bus_addr", bus_addr, 0);
        inst_req = 1; settle();
        check_eq("rst_if_stall", if_stall, 1);
        inst_req = 0;
        rst = 0;
        cyc();

        // Single fetch, minimum latency
        inst_req = 1; inst_addr = 32'hBFC0_0000; settle();
        check_eq("f_idle_bus_req", bus_req, 0);
        check_eq("f_idle_if_stall", if_stall, 1);
        cyc();
        bus_addr_ok = 1; settle();
        check_eq("f_bus_req", bus_req, 1);
        check_eq("f_bus_addr", bus_addr, 32'hBFC0_0000);
        check_eq("f_bus_size", bus_size, 2);
        check_eq("f_bus_wr", bus_wr, 0);
        check_eq("f_ok_early", inst_data_ok, 0);
        cyc();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1234_5678; settle();
        check_eq("f_bus_req_data", bus_req, 0);
        check_eq("f_inst_ok", inst_data_ok, 1);
        check_eq("f_inst_rdata", inst_rdata, 32'h1234_5678);
        check_eq("f_if_stall_done", if_stall, 0);
        cyc();
        inst_req = 0; bus_data_ok = 1; bus_rdata = 32'hFFFF_FFFF; settle();
        check_eq("idle_stray_inst_ok", inst_data_ok, 0);
        check_eq("idle_stray_data_ok", data_data_ok, 0);
        cyc();
        bus_data_ok = 0; settle();
        check_eq("idle_stray_no_req", bus_req, 0);

        // Simultaneous store and fetch: store first
        inst_req = 1; inst_addr = 32'hBFC0_0004;
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h8000_1000; data_wdata = 32'hDEAD_BEEF;
        cyc();
        bus_addr_ok = 1; settle();
        check_eq("sf_d_bus_req", bus_req, 1);
        check_eq("sf_d_bus_wr", bus_wr, 1);
        check_eq("sf_d_bus_addr", bus_addr, 32'h8000_1000);
        check_eq("sf_d_bus_wdata", bus_wdata, 32'hDEAD_BEEF);
        check_eq("sf_if_stall_a", if_stall, 1);
        check_eq("sf_mem_stall_a", mem_stall, 1);
        cyc();
        bus_addr_ok = 0; bus_data_ok = 1; settle();
        check_eq("sf_data_ok", data_data_ok, 1);
        check_eq("sf_inst_ok_not", inst_data_ok, 0);
        check_eq("sf_mem_stall_done", mem_stall, 0);
        check_eq("sf_if_stall_b", if_stall, 1);
        cyc();
        data_req = 0; data_wr = 0; bus_data_ok = 0; settle();
        check_eq("sf_gap_bus_req", bus_req, 0);
        check_eq("sf_if_stall_c", if_stall, 1);
        cyc();
        bus_addr_ok = 1; settle();
        check_eq("sf_i_bus_req", bus_req, 1);
        check_eq("sf_i_bus_addr", bus_addr, 32'hBFC0_0004);
        check_eq("sf_i_bus_wr", bus_wr, 0);
        check_eq("sf_if_stall_d", if_stall, 1);
        cyc();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hAAAA_5555; settle();
        check_eq("sf_inst_ok", inst_data_ok, 1);
        check_eq("sf_inst_rdata", inst_rdata, 32'hAAAA_5555);
        cyc();
        inst_req = 0; bus_data_ok = 0;

        // Byte load with addr_ok and data_ok together in D_ADDR
        data_req = 1; data_wr = 0; data_size = 0; data_addr = 32'h0000_0003;
        cyc();
        bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'h0000_00AB; settle();
        check_eq("ld_bus_size", bus_size, 0);
        check_eq("ld_bus_wr", bus_wr, 0);
        check_eq("ld_same_cycle_ok", data_data_ok, 1);
        check_eq("ld_rdata", data_rdata, 32'h0000_00AB);
        cyc();
        data_req = 0; bus_addr_ok = 0; bus_data_ok = 0; settle();
        check_eq("ld_back_idle", bus_req, 0);
        cyc();

        // Fetch cancelled in I_DATA, completion 4 cycles later is dropped
        inst_req = 1; inst_addr = 32'hBFC0_0008;
        cyc();
        bus_addr_ok = 1;
        cyc();
        bus_addr_ok = 0; inst_cancel = 1; settle();
        check_eq("cx_cancel_ok", inst_data_ok, 0);
        cyc();
        inst_cancel = 0; inst_addr = 32'hBFC0_0100;
        cyc(); cyc(); cyc();
        bus_data_ok = 1; bus_rdata = 32'hBAD0_BAD0; settle();
        check_eq("cx_dropped_ok", inst_data_ok, 0);
        check_eq("cx_dropped_rdata", inst_rdata, 0);
        check_eq("cx_if_stall", if_stall, 1);
        cyc();
        bus_data_ok = 0; settle();
        check_eq("cx_idle_bus_req", bus_req, 0);
        cyc();
        bus_addr_ok = 1; settle();
        check_eq("cx_next_bus_addr", bus_addr, 32'hBFC0_0100);
        check_eq("cx_next_bus_req", bus_req, 1);
        cyc();
        bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h1111_2222; settle();
        check_eq("cx_next_ok", inst_data_ok, 1);
        check_eq("cx_next_rdata", inst_rdata, 32'h1111_2222);
        cyc();
        inst_req = 0; bus_data_ok = 0;

        // Half load with addr_ok delayed: bus outputs held from the latch; cancel ignored
        data_req = 1; data_wr = 0; data_size = 1; data_addr = 32'h8000_2002;
        cyc();
        inst_cancel = 1;
        for (int i = 0; i < 5; i++) begin
            data_addr = 32'h0BAD_0000 + i;
            bus_addr_ok = (i == 4);
            settle();
            check_eq("wait_bus_req", bus_req, 1);
            check_eq("wait_bus_addr", bus_addr, 32'h8000_2002);
            check_eq("wait_bus_size", bus_size, 1);
            cyc();
            inst_cancel = 0;
        end
        bus_addr_ok = 0; settle();
        check_eq("wait_ddata_req", bus_req, 0);
        bus_data_ok = 1; bus_rdata = 32'h0000_BEEF; settle();
        check_eq("wait_data_ok", data_data_ok, 1);
        check_eq("wait_rdata", data_rdata, 32'h0000_BEEF);
        cyc();
        data_req = 0; bus_data_ok = 0;

        // Reset in D_DATA abandons the store
        data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h8000_3000; data_wdata = 32'h0102_0304;
        cyc();
        bus_addr_ok = 1;
        cyc();
        bus_addr_ok = 0; rst = 1; bus_data_ok = 1; settle();
        check_eq("rd_rst_data_ok", data_data_ok, 0);
        cyc();
        rst = 0; data_req = 0; data_wr = 0; settle();
        check_eq("rd_after_data_ok", data_data_ok, 0);
        check_eq("rd_after_bus_req", bus_req, 0);
        check_eq("rd_after_addr", bus_addr, 0);
        cyc();
        bus_data_ok = 0; settle();
        check_eq("rd_idle_bus_req", bus_req, 0);
        check_eq("rd_idle_data_ok", data_data_ok, 0);

`ifdef MEM_ARB_RR_EN
        // Continuous dual requests alternate D, I, D, I
        inst_req = 1; inst_addr = 32'hBFC0_0200;
        data_req = 1; data_wr = 1; data_addr = 32'h8000_4000; data_wdata = 32'h5A5A_5A5A;
        for (int k = 0; k < 4; k++) begin
            cyc();
            bus_addr_ok = 1; bus_data_ok = 1; settle();
            check_eq("rr_bus_wr", bus_wr, (k % 2 == 0) ? 1 : 0);
            check_eq("rr_data_ok", data_data_ok, (k % 2 == 0) ? 1 : 0);
            check_eq("rr_inst_ok", inst_data_ok, (k % 2 == 0) ? 0 : 1);
            cyc();
            bus_addr_ok = 0; bus_data_ok = 0;
        end
        inst_req = 0; data_req = 0;
`endif

        cyc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 inst_req  in  1  fetch request, held high until inst_data_ok.
REQ-004 inst_addr  in  32  fetch byte address.
REQ-005 inst_cancel  in  1  one-cycle pulse: exception/branch flush of the fetch in flight.
REQ-006 inst_rdata, inst_data_ok  out  32, 1  fetch word and one-cycle completion strobe.
REQ-007 data_req, data_wr  in  1, 1  load/store request (held until data_data_ok), 1 = store.
REQ-008 data_size, data_addr, data_wdata  in  2, 32, 32  access size (0 = byte, 1 = half, 2 = word), address, store data.
REQ-009 data_rdata, data_data_ok  out  32, 1  load data and one-cycle completion strobe.
REQ-010 bus_req, bus_wr, bus_size, bus_addr, bus_wdata  out  1, 1, 2, 32, 32  single shared SRAM-like bus request.
REQ-011 bus_addr_ok, bus_data_ok, bus_rdata  in  1, 1, 32  address accept, completion, read data.
REQ-012 if_stall, mem_stall  out  1, 1  stall requests to the hazard unit.

Function
REQ-013 FSM states SHALL be IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA, with at most one bus transaction outstanding.
REQ-014 In IDLE, a pending data_req SHALL win over inst_req (fixed priority).
REQ-015 On grant, the winner's address, size, write flag and wdata SHALL be latched, and the FSM SHALL enter X_ADDR on the next edge; fetch uses size 2 and wr 0.
REQ-016 bus_req SHALL be 1 exactly in I_ADDR/D_ADDR; bus outputs SHALL come only from the latched registers.
REQ-017 X_ADDR SHALL go to X_DATA in the cycle after bus_addr_ok = 1; otherwise it SHALL hold.
REQ-018 X_DATA SHALL go to IDLE on bus_data_ok = 1, asserting the matching *_data_ok for that cycle only, with *_rdata = bus_rdata.
REQ-019 Minimum latency (addr_ok and data_ok each one cycle after issue) SHALL be 3 cycles from request to data_ok.
REQ-020 inst_cancel in I_ADDR or I_DATA SHALL set a drop flag; the transaction SHALL still complete on the bus, but inst_data_ok SHALL be suppressed.
REQ-021 The drop flag SHALL clear on return to IDLE.
REQ-022 inst_cancel in IDLE or in D states SHALL have no effect.
REQ-023 bus_addr_ok and bus_data_ok in the same cycle in X_ADDR SHALL be treated as completion: return to IDLE and assert *_data_ok.
REQ-024 bus_data_ok in IDLE SHALL be ignored.
REQ-025 if_stall SHALL equal inst_req & ~inst_data_ok; mem_stall SHALL equal data_req & ~data_data_ok.
REQ-026 A request arriving in the same cycle as a completion SHALL be granted from IDLE on the following cycle, with no back-to-back overlap.

Reset
REQ-027 rst SHALL force IDLE and clear the drop flag and latched registers.
REQ-028 Outputs SHALL reset to: bus_req 0, *_data_ok 0, *_rdata 0, stalls per REQ-025.
REQ-029 rst mid-transaction SHALL abandon it; no data_ok SHALL follow.

Configuration
REQ-030 Macro MEM_ARB_RR_EN defined: a last-grant bit SHALL alternate priority when both requests are pending in IDLE.
REQ-031 MEM_ARB_RR_EN undefined: fixed data priority (REQ-014) SHALL apply, and the last-grant bit SHALL not exist.

Structure
REQ-032 Shared package SHALL hold the FSM state encoding, size encodings (SZ_BYTE/SZ_HALF/SZ_WORD) and the 32-bit width constant.
REQ-033 No sub-module SHALL be used; the FSM and latches SHALL be a single module.

Verification
REQ-034 Scenario: inst_req, addr 0xBFC00000, addr_ok and data_ok one cycle each -> bus_addr 0xBFC00000, inst_data_ok on the 3rd cycle, rdata passthrough.
REQ-035 Scenario: inst_req and data_req (store 0x80001000, wdata 0xDEADBEEF) in the same cycle -> store issued first with bus_wr 1, then fetch, if_stall held throughout.
REQ-036 Scenario: inst_cancel in I_DATA with data_ok 4 cycles later -> no inst_data_ok, FSM returns to IDLE, next fetch served normally.
REQ-037 Scenario: addr_ok delayed 5 cycles -> bus_req held 5 cycles with bus outputs stable.
REQ-038 Scenario: rst during D_DATA -> IDLE next cycle, no data_data_ok.
REQ-039 Scenario: with MEM_ARB_RR_EN, continuous dual requests -> grants alternate D, I, D, I.
